// File: rtl/parallel_adder_pkg.sv
// -----------------------------------------------------------------------------
// parallel_adder_pkg
//   Shared definitions for the pipelined parallel adder:
//     - op_t         : 2-bit operation code (ADD, SUB, ACC, CLR)
//     - DEF_WIDTH    : default operand width per lane
//     - DEF_LANES    : default number of lanes
//     - STAGES       : register stages between accept and deliver
//     - BEAT_CNT_W   : width of the delivered-result counter
//     - writes_acc() : true for ops that update the lane accumulator
// -----------------------------------------------------------------------------
package parallel_adder_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_LANES  = 12;
    localparam int STAGES     = 2;
    localparam int BEAT_CNT_W = 16;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_ACC = 2'd2,
        OP_CLR = 2'd3
    } op_t;

    function automatic logic writes_acc(input op_t op);
        return (op == OP_ACC) || (op == OP_CLR);
    endfunction

endpackage

// File: rtl/parallel_adder_pipe_if.sv
// -----------------------------------------------------------------------------
// parallel_adder_pipe_if
//   Operand stream in, result stream out, both ready/valid.
//     in_valid/in_ready  : operand beat handshake
//     in_op              : operation for the whole beat
//     in_a/in_b          : lane k operand at [k] (== bits [k*WIDTH +: WIDTH])
//     out_valid/out_ready: result beat handshake
//     out_sum            : lane k result at [k] (WIDTH+1 bits)
//     out_sat            : lane k accumulator clamped on this beat
//     out_beats          : delivered-result count, wraps
//   master = source/consumer side, slave = the adder block.
// -----------------------------------------------------------------------------
interface parallel_adder_pipe_if
    import parallel_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES
);
    logic                             in_valid;
    logic                             in_ready;
    op_t                              in_op;
    logic [LANES-1:0][WIDTH-1:0]      in_a;
    logic [LANES-1:0][WIDTH-1:0]      in_b;
    logic                             out_valid;
    logic                             out_ready;
    logic [LANES-1:0][WIDTH:0]        out_sum;
    logic [LANES-1:0]                 out_sat;
    logic [BEAT_CNT_W-1:0]            out_beats;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_sat, out_beats
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_sat, out_beats
    );

endinterface

// File: rtl/adder_lane.sv
// -----------------------------------------------------------------------------
// adder_lane
//   One lane of the parallel adder: computes the stage-2 result from the
//   stage-1 operands and owns the lane's saturating accumulator.
//     clk, rst_n : clock, async active-low reset
//     adv        : the stage-1 beat moves into stage 2 this cycle
//     op         : stage-1 operation
//     a, b       : stage-1 operands (unsigned)
//     sum, sat   : stage-2 result registers
// -----------------------------------------------------------------------------
module adder_lane
    import parallel_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum,
    output logic             sat
);

    localparam logic [WIDTH:0] ACC_MAX = '1;

    logic [WIDTH:0]   acc;
    logic [WIDTH+1:0] acc_raw;   // one spare bit: acc + a + b < 2^(WIDTH+2)
    logic [WIDTH:0]   sum_next;
    logic             sat_next;

    always_comb begin
        acc_raw  = {1'b0, acc} + {2'b00, a} + {2'b00, b};
        sum_next = '0;
        sat_next = 1'b0;
        case (op)
            OP_ADD: sum_next = {1'b0, a} + {1'b0, b};
            OP_SUB: sum_next = {1'b0, a} - {1'b0, b};
            OP_ACC: begin
                if (acc_raw[WIDTH+1]) begin
                    sum_next = ACC_MAX;
                    sat_next = 1'b1;
                end else begin
                    sum_next = acc_raw[WIDTH:0];
                end
            end
            default: sum_next = '0;   // CLR
        endcase
    end

    // The accumulator is written on the same edge the result enters stage 2,
    // so a following ACC beat already sitting in stage 1 reads the new value
    // directly: back-to-back accumulation needs no separate bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            sum <= '0;
            sat <= 1'b0;
        end else if (adv) begin
            sum <= sum_next;
            sat <= sat_next;
            if (writes_acc(op)) acc <= sum_next;   // CLR's sum_next is zero
        end
    end

endmodule

// File: rtl/parallel_adder_pipe.sv
// -----------------------------------------------------------------------------
// parallel_adder_pipe
//   Two-stage pipelined array of LANES independent adder lanes with
//   ready/valid on both sides.
//     clk, rst_n : clock, async active-low reset
//     bus        : parallel_adder_pipe_if.slave (operand in, result out,
//                  out_beats delivered-result counter)
//   Stage 1 registers operands/op; stage 2 (inside each lane) holds results.
//   A beat accepted in cycle n is presented in cycle n+2 when not stalled.
// -----------------------------------------------------------------------------
module parallel_adder_pipe
    import parallel_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    parallel_adder_pipe_if.slave bus
);

    logic [STAGES:1]             vld_pipe;   // [1] = S1 valid, [2] = S2 valid
    logic                        adv1;
    logic                        adv2;
    logic                        lane_adv;
    op_t                         s1_op;
    logic [LANES-1:0][WIDTH-1:0] s1_a;
    logic [LANES-1:0][WIDTH-1:0] s1_b;
    logic [LANES-1:0][WIDTH:0]   lane_sum;
    logic [LANES-1:0]            lane_sat;
    logic [BEAT_CNT_W-1:0]       beats;

    // Each stage may load when it is empty or its content leaves this cycle.
    // in_ready depends on out_ready only, never on in_valid.
    assign adv2     = ~vld_pipe[2] | bus.out_ready;
    assign adv1     = ~vld_pipe[1] | adv2;
    assign lane_adv = adv2 & vld_pipe[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_op    <= OP_ADD;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            if (adv1) begin
                vld_pipe[1] <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_op <= bus.in_op;
                    s1_a  <= bus.in_a;
                    s1_b  <= bus.in_b;
                end
            end
            if (adv2) vld_pipe[2] <= vld_pipe[1];
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        adder_lane #(.WIDTH(WIDTH)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .adv   (lane_adv),
            .op    (s1_op),
            .a     (s1_a[k]),
            .b     (s1_b[k]),
            .sum   (lane_sum[k]),
            .sat   (lane_sat[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           beats <= '0;
        else if (vld_pipe[2] & bus.out_ready) beats <= beats + 1'b1;
    end

    assign bus.in_ready  = adv1;
    assign bus.out_valid = vld_pipe[2];
    assign bus.out_sum   = lane_sum;
    assign bus.out_sat   = lane_sat;
    assign bus.out_beats = beats;

endmodule
